cpu_clock_ctrl: RTL
===================

// Module: cpu_clock_ctrl
// PURPOSE
//   Run/halt/single-step controller and multi-cycle phase sequencer for the RISC CPU.
//   Consumes the free-running system clock and issues a one-hot phase enable
//   (FETCH, DECODE, EXEC, MEM, WB) plus a global cpu_en to the datapath.
//   Halts only at instruction boundaries; counts cycles and retired instructions.
// PARAMETERS
//   CNT_W   32   width of cycle_count and instr_count (wrap modulo 2^CNT_W)
// PORTS
//   clock        in   1      system clock; all state changes on its rising edge
//   reset_n      in   1      asynchronous, active-low reset
//   run_req      in   1      1-cycle pulse: start free-running execution
//   halt_req     in   1      1-cycle pulse: stop at the next instruction boundary
//   step_req     in   1      1-cycle pulse: execute exactly one instruction (from HALTED)
//   halt_instr   in   1      decoder flag: HLT instruction is in EXEC
//   stall        in   1      memory wait; freezes the phase while high
//   cpu_en       out  1      datapath clock enable for this cycle
//   phase_oh     out  5      one-hot phase {WB,MEM,EXEC,DECODE,FETCH}, gated by cpu_en
//   retire       out  1      1-cycle pulse: instruction completes WB this cycle
//   halted       out  1      controller is in HALTED
//   cycle_count  out  CNT_W  cycles spent outside HALTED
//   instr_count  out  CNT_W  retired instructions
// BEHAVIOUR
//   - States: HALTED, RUN, STEP, DRAIN. The phase register cycles FETCH->DECODE->EXEC->MEM->WB->FETCH.
//   - Reset (async, takes effect immediately, also mid-instruction): state=HALTED,
//     phase=FETCH, cycle_count=0, instr_count=0. All outputs are 0 except halted=1.
//   - active = state!=HALTED. cpu_en = active & ~stall. phase_oh = onehot(phase) if cpu_en, else 0.
//   - The phase advances only when cpu_en is high. When stall is high, the phase holds
//     and no output pulses.
//   - retire = cpu_en & phase==WB. instr_count += 1 on retire.
//     cycle_count += 1 every cycle in which active is high, including stalled cycles.
//   - halt_ev = halt_req | (halt_instr & cpu_en & phase==EXEC).
//   - Request priority on the same cycle: halt_req > run_req > step_req.
//   - Transitions:
//       HALTED: run_req->RUN; else step_req->STEP; halt_req is ignored.
//               The phase is always FETCH in HALTED.
//       RUN:    halt_ev & retire->HALTED; halt_ev & ~retire->DRAIN; step_req is ignored.
//       STEP:   retire->HALTED; run_req & ~halt_req->RUN (upgrade);
//               halt_req is a no-op and the step still completes.
//       DRAIN:  retire->HALTED; run_req & ~halt_req->RUN (cancels the pending halt).
//   - Latency: from run_req/step_req high (sampled at edge N), cpu_en=1 with FETCH in cycle N+1.
//     An unstalled instruction takes 5 cycles; in STEP, halted=1 in the cycle after retire.
//   - HLT always completes through WB before halting. A halt_req during WB with cpu_en
//     goes directly to HALTED in the next cycle, with no extra instruction executed.
//   - Counters wrap silently at 2^CNT_W-1 -> 0.
//   - Pulse inputs held high for multiple cycles are re-evaluated each cycle per the
//     rules above; no edge detection.
// TESTING
//   1 Reset: assert reset_n=0 during RUN/EXEC -> same cycle: halted=1, phase_oh=0, counters=0.
//   2 Single step: step_req pulse from HALTED, no stall -> phase_oh 00001,00010,00100,01000,10000
//     on 5 consecutive cycles, retire on the 5th, then halted=1, instr_count=1, cycle_count=5.
//   3 Stall: RUN with stall=1 for 3 cycles during MEM -> phase_oh=0 and phase held;
//     instr takes 8 cycles, cycle_count=8, instr_count=1.
//   4 HLT: run 2 instructions, halt_instr=1 during the 3rd instruction's EXEC -> that instruction
//     retires, halted=1 next cycle, instr_count=3, cycle_count=15.
//   5 Halt during WB: halt_req in the same cycle as retire -> HALTED next cycle, no DRAIN visit.
//     Simultaneous halt_req+run_req in HALTED -> stays HALTED.
//   6 Cancel: halt_req in DECODE, then run_req in MEM -> RUN continues, no halt at WB.
//     Preload counters near 2^CNT_W-1 (CNT_W=4) -> wrap to 0.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
//   Run/halt/single-step controller and five-phase instruction sequencer for
//   the RISC CPU. A free-running system clock drives the block. It produces a
//   datapath clock enable (cpu_en) and a one-hot phase enable
//   {WB,MEM,EXEC,DECODE,FETCH}. Execution stops only at instruction
//   boundaries, meaning after the WB phase retires. The block also keeps
//   wrapping counters of active cycles and retired instructions.
//
// Parameters
//   CNT_W        width of cycle_count / instr_count (wrap modulo 2^CNT_W)
//
// Ports
//   clock        in   system clock, all state changes on its rising edge
//   reset_n      in   asynchronous active-low reset
//   run_req      in   pulse: start free-running execution
//   halt_req     in   pulse: stop at the next instruction boundary
//   step_req     in   pulse: execute exactly one instruction (from HALTED)
//   halt_instr   in   decoder flag: HLT instruction is in EXEC
//   stall        in   memory wait, freezes the phase while high
//   cpu_en       out  datapath clock enable for this cycle
//   phase_oh     out  one-hot phase {WB,MEM,EXEC,DECODE,FETCH}, gated by cpu_en
//   retire       out  pulse: instruction completes WB this cycle
//   halted       out  controller is in HALTED
//   cycle_count  out  cycles spent outside HALTED (stalled cycles included)
//   instr_count  out  retired instructions
// -----------------------------------------------------------------------------
module cpu_clock_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             halt_instr,
    input  logic             stall,
    output logic             cpu_en,
    output logic [4:0]       phase_oh,
    output logic             retire,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    // -------------------------------------------------------------------------
    // Controller states
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_HALTED = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    // -------------------------------------------------------------------------
    // Instruction phases (binary encoded, decoded to one-hot at the output)
    // -------------------------------------------------------------------------
    localparam logic [2:0] PH_FETCH  = 3'd0;
    localparam logic [2:0] PH_DECODE = 3'd1;
    localparam logic [2:0] PH_EXEC   = 3'd2;
    localparam logic [2:0] PH_MEM    = 3'd3;
    localparam logic [2:0] PH_WB     = 3'd4;

    logic [1:0]       r_state;
    logic [2:0]       r_phase;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic [1:0]       w_state_nxt;
    logic [2:0]       w_phase_nxt;
    logic [2:0]       w_phase_inc;
    logic [4:0]       w_phase_dec;
    logic             w_active;
    logic             w_cpu_en;
    logic             w_in_exec;
    logic             w_in_wb;
    logic             w_retire;
    logic             w_halt_ev;
    logic             w_run_ok;

    // -------------------------------------------------------------------------
    // Status and enables
    // -------------------------------------------------------------------------
    assign w_active  = (r_state != S_HALTED);
    assign w_cpu_en  = w_active & ~stall;
    assign w_in_exec = (r_phase == PH_EXEC);
    assign w_in_wb   = (r_phase == PH_WB);
    assign w_retire  = w_cpu_en & w_in_wb;

    // A HLT only counts when its EXEC phase actually executes. If it is
    // stalled, it is seen again on the cycle the stall lifts.
    assign w_halt_ev = halt_req | (halt_instr & w_cpu_en & w_in_exec);

    // A run request loses to a halt request presented on the same cycle.
    assign w_run_ok  = run_req & ~halt_req;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HALTED: begin
                // A halt_req blocks run/step on the same cycle. It has no
                // other effect here.
                if (!halt_req) begin
                    if (run_req) begin
                        w_state_nxt = S_RUN;
                    end else if (step_req) begin
                        w_state_nxt = S_STEP;
                    end
                end
            end
            S_RUN: begin
                // Halting on the WB cycle itself skips DRAIN, so no further
                // instruction is started.
                if (w_halt_ev) begin
                    w_state_nxt = w_retire ? S_HALTED : S_DRAIN;
                end
            end
            S_STEP, S_DRAIN: begin
                // Both finish the current instruction and then stop. A run
                // request upgrades a step or cancels a pending halt.
                if (w_retire) begin
                    w_state_nxt = S_HALTED;
                end else if (w_run_ok) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_HALTED;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Phase sequencer
    // -------------------------------------------------------------------------
    always_comb begin
        w_phase_inc = PH_FETCH;
        case (r_phase)
            PH_FETCH:  w_phase_inc = PH_DECODE;
            PH_DECODE: w_phase_inc = PH_EXEC;
            PH_EXEC:   w_phase_inc = PH_MEM;
            PH_MEM:    w_phase_inc = PH_WB;
            PH_WB:     w_phase_inc = PH_FETCH;
            default:   w_phase_inc = PH_FETCH;
        endcase
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (!w_active) begin
            // Parked at the start of an instruction while halted.
            w_phase_nxt = PH_FETCH;
        end else if (w_cpu_en) begin
            w_phase_nxt = w_phase_inc;
        end
    end

    // -------------------------------------------------------------------------
    // One-hot phase decode, gated by the datapath enable
    // -------------------------------------------------------------------------
    always_comb begin
        w_phase_dec = 5'b00000;
        case (r_phase)
            PH_FETCH:  w_phase_dec = 5'b00001;
            PH_DECODE: w_phase_dec = 5'b00010;
            PH_EXEC:   w_phase_dec = 5'b00100;
            PH_MEM:    w_phase_dec = 5'b01000;
            PH_WB:     w_phase_dec = 5'b10000;
            default:   w_phase_dec = 5'b00000;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HALTED;
            r_phase <= PH_FETCH;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Counters (wrap silently)
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_cnt <= '0;
        end else if (w_active) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr_cnt <= '0;
        end else if (w_retire) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // All outputs are decoded from state, so an asynchronous reset is
    // visible in the same cycle.
    assign cpu_en      = w_cpu_en;
    assign phase_oh    = w_cpu_en ? w_phase_dec : 5'b00000;
    assign retire      = w_retire;
    assign halted      = ~w_active;
    assign cycle_count = r_cycle_cnt;
    assign instr_count = r_instr_cnt;

endmodule
